// File: rtl/cond_pkg.sv
// Shared definitions for the input conditioner: debounce FSM state
// encoding, debounce counter width and the legal DEBOUNCE_CYCLES range.
package cond_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } deb_state_e;

    localparam int unsigned CNT_W        = 8;
    localparam int unsigned DEBOUNCE_MIN = 2;
    localparam int unsigned DEBOUNCE_MAX = 255;

endpackage

// File: rtl/debounce_channel.sv
// One conditioning channel: 2-flop synchronizer, debounce FSM with its
// qualification counter, registered level/pulse outputs and a saturating
// count of rejected transitions.
module debounce_channel
    import cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                raw_i,
    output logic                level_o,
    output logic                pulse_o,
    output logic [GLITCH_W-1:0] glitches_o
);

    // Sample count at which the current candidate transition is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    deb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                pulse_q, pulse_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_inc;

    // Two-stage synchronizer bringing the asynchronous raw input into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered-output storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            glitch_q <= glitch_d;
        end
    end

    // Next-state and qualification-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (sync2_q) begin
                    state_d = RISE_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            RISE_CHK: begin
                if (!sync2_q) begin
                    state_d = LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = FALL_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            FALL_CHK: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = LOW;
        endcase
    end

    // Next values of level, rise pulse and saturating glitch count.
    always_comb begin
        level_d    = level_q;
        pulse_d    = 1'b0;
        glitch_inc = 1'b0;
        case (state_q)
            RISE_CHK: begin
                if (!sync2_q) begin
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end
            end
            FALL_CHK: begin
                if (sync2_q) begin
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = 1'b0;
                end
            end
            default: ;
        endcase
        glitch_d = (glitch_inc && (glitch_q != '1)) ? glitch_q + GLITCH_W'(1) : glitch_q;
    end

    assign level_o    = level_q;
    assign pulse_o    = pulse_q;
    assign glitches_o = glitch_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw S (start) and X (count) inputs with two identical,
// independent debounce channels.
module input_conditioner
    import cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                s_raw,
    input  logic                x_raw,
    output logic                s_level,
    output logic                s_pulse,
    output logic                x_level,
    output logic                x_pulse,
    output logic [GLITCH_W-1:0] s_glitches,
    output logic [GLITCH_W-1:0] x_glitches
);

    if ((DEBOUNCE_CYCLES < DEBOUNCE_MIN) || (DEBOUNCE_CYCLES > DEBOUNCE_MAX)) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES=%0d outside %0d..%0d",
               DEBOUNCE_CYCLES, DEBOUNCE_MIN, DEBOUNCE_MAX);
    end

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .GLITCH_W        (GLITCH_W)
    ) u_s_chan (
        .clock      (clock),
        .reset      (reset),
        .raw_i      (s_raw),
        .level_o    (s_level),
        .pulse_o    (s_pulse),
        .glitches_o (s_glitches)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .GLITCH_W        (GLITCH_W)
    ) u_x_chan (
        .clock      (clock),
        .reset      (reset),
        .raw_i      (x_raw),
        .level_o    (x_level),
        .pulse_o    (x_pulse),
        .glitches_o (x_glitches)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with constant
// expectations plus randomized stimulus against a run-length model.
module tb_input_conditioner;

    localparam int unsigned DEB    = 4;
    localparam int unsigned GW     = 8;
    localparam int unsigned GW_SAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic s_raw = 1'b0, x_raw = 1'b0;
    logic sat_s_raw = 1'b0, sat_x_raw = 1'b0;

    logic s_level, s_pulse, x_level, x_pulse;
    logic [GW-1:0] s_glitches, x_glitches;
    logic sat_s_level, sat_s_pulse, sat_x_level, sat_x_pulse;
    logic [GW_SAT-1:0] sat_s_glitches, sat_x_glitches;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    input_conditioner #(.DEBOUNCE_CYCLES(DEB), .GLITCH_W(GW)) dut (
        .clock(clock), .reset(reset), .s_raw(s_raw), .x_raw(x_raw),
        .s_level(s_level), .s_pulse(s_pulse), .x_level(x_level), .x_pulse(x_pulse),
        .s_glitches(s_glitches), .x_glitches(x_glitches)
    );

    input_conditioner #(.DEBOUNCE_CYCLES(DEB), .GLITCH_W(GW_SAT)) dut_sat (
        .clock(clock), .reset(reset), .s_raw(sat_s_raw), .x_raw(sat_x_raw),
        .s_level(sat_s_level), .s_pulse(sat_s_pulse), .x_level(sat_x_level), .x_pulse(sat_x_pulse),
        .s_glitches(sat_s_glitches), .x_glitches(sat_x_glitches)
    );

    // Reference model: after a 2-sample synchronizer delay, the level flips
    // once DEB consecutive samples disagree with it; a disagreeing run that
    // ends early is one glitch. Channels: 0=S, 1=X, 2=sat S, 3=sat X.
    logic [3:0] raw_vec;
    assign raw_vec = {sat_x_raw, sat_s_raw, x_raw, s_raw};

    bit m_sync1[4], m_sync2[4], m_level[4], m_pulse[4], m_seen[4];
    int m_run[4], m_glitch[4];
    int m_max[4] = '{(1 << GW) - 1, (1 << GW) - 1, (1 << GW_SAT) - 1, (1 << GW_SAT) - 1};

    always @(posedge clock) begin
        for (int c = 0; c < 4; c++) begin
            if (reset) begin
                m_sync1[c] = 0; m_sync2[c] = 0; m_level[c] = 0;
                m_pulse[c] = 0; m_run[c] = 0; m_glitch[c] = 0;
            end else begin
                m_seen[c]  = m_sync2[c];
                m_sync2[c] = m_sync1[c];
                m_sync1[c] = raw_vec[c];
                m_pulse[c] = 0;
                if (m_seen[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == int'(DEB)) begin
                        m_level[c] = m_seen[c];
                        m_pulse[c] = m_seen[c];
                        m_run[c]   = 0;
                    end
                end else if (m_run[c] != 0) begin
                    if (m_glitch[c] < m_max[c]) m_glitch[c]++;
                    m_run[c] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        s_raw = 0; x_raw = 0; sat_s_raw = 0; sat_x_raw = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({s_level, s_pulse, x_level, x_pulse, s_glitches, x_glitches} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0",
                     {s_level, s_pulse, x_level, x_pulse, s_glitches, x_glitches});
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if ({s_level, s_pulse, x_level, x_pulse, s_glitches, x_glitches} !== '0) begin
                miscompares++;
                $display("FAIL idle_zero cycle %0d: got %h expected 0", k,
                         {s_level, s_pulse, x_level, x_pulse, s_glitches, x_glitches});
            end
        end
    endtask

    task automatic test_x_rise_fall();
        int pulses;
        do_reset();
        pulses = 0;
        x_raw = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (x_pulse === 1'b1) pulses++;
            vectors++;
            if (x_level !== (k >= int'(DEB) + 1) || x_pulse !== (k == int'(DEB) + 1)) begin
                miscompares++;
                $display("FAIL x_rise edge %0d: got level=%b pulse=%b expected level=%b pulse=%b",
                         k, x_level, x_pulse, (k >= int'(DEB) + 1), (k == int'(DEB) + 1));
            end
        end
        vectors++;
        if (pulses != 1 || x_glitches !== '0 || s_level !== 1'b0) begin
            miscompares++;
            $display("FAIL x_rise_summary: got pulses=%0d glitches=%0d s_level=%b expected 1/0/0",
                     pulses, x_glitches, s_level);
        end
        x_raw = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (x_level !== (k < int'(DEB) + 1) || x_pulse !== 1'b0) begin
                miscompares++;
                $display("FAIL x_fall edge %0d: got level=%b pulse=%b expected level=%b pulse=0",
                         k, x_level, x_pulse, (k < int'(DEB) + 1));
            end
        end
    endtask

    task automatic test_s_glitch();
        do_reset();
        s_raw = 1;
        tick();
        tick();
        s_raw = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            vectors++;
            if (s_level !== 1'b0 || s_pulse !== 1'b0) begin
                miscompares++;
                $display("FAIL s_glitch_quiet cycle %0d: got level=%b pulse=%b expected 0/0",
                         k, s_level, s_pulse);
            end
        end
        vectors++;
        if (s_glitches !== GW'(1)) begin
            miscompares++;
            $display("FAIL s_glitch_count: got %0d expected 1", s_glitches);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        do_reset();
        pulses = 0;
        for (int b = 0; b < 20; b++) begin
            x_raw = 1;
            tick();
            if (x_pulse === 1'b1) pulses++;
            x_raw = 0;
            tick();
            if (x_pulse === 1'b1) pulses++;
        end
        x_raw = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (x_pulse === 1'b1) pulses++;
        end
        vectors++;
        if (x_glitches !== GW'(20) || pulses != 1 || x_level !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce: got glitches=%0d pulses=%0d level=%b expected 20/1/1",
                     x_glitches, pulses, x_level);
        end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        do_reset();
        for (int g = 1; g <= 8; g++) begin
            sat_s_raw = 1; sat_x_raw = 1;
            tick();
            sat_s_raw = 0; sat_x_raw = 0;
            for (int k = 0; k < 4; k++) tick();
            exp_cnt = (g > 3) ? 3 : g;
            vectors++;
            if (sat_s_glitches !== GW_SAT'(exp_cnt) || sat_x_glitches !== GW_SAT'(exp_cnt)) begin
                miscompares++;
                $display("FAIL saturate after %0d glitches: got s=%0d x=%0d expected %0d",
                         g, sat_s_glitches, sat_x_glitches, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_raw = 1;
        for (int k = 0; k < 8; k++) tick();
        vectors++;
        if (s_level !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got level=%b expected 1", s_level);
        end
        reset = 1;
        tick();
        reset = 0;
        vectors++;
        if (s_level !== 1'b0 || s_pulse !== 1'b0 || s_glitches !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: got level=%b pulse=%b glitches=%0d expected 0/0/0",
                     s_level, s_pulse, s_glitches);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            vectors++;
            if (s_level !== (k >= int'(DEB) + 2) || s_pulse !== (k == int'(DEB) + 2)) begin
                miscompares++;
                $display("FAIL reset_mid_requal edge %0d: got level=%b pulse=%b expected level=%b pulse=%b",
                         k, s_level, s_pulse, (k >= int'(DEB) + 2), (k == int'(DEB) + 2));
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        s_raw = 1;
        x_raw = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (s_pulse !== (k == int'(DEB) + 1) || x_pulse !== (k == int'(DEB) + 1)) begin
                miscompares++;
                $display("FAIL simultaneous edge %0d: got s_pulse=%b x_pulse=%b expected %b",
                         k, s_pulse, x_pulse, (k == int'(DEB) + 1));
            end
        end
    endtask

    task automatic test_random();
        int hold[4];
        logic [3:0] r;
        do_reset();
        for (int c = 0; c < 4; c++) hold[c] = 0;
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    r[c]    = ~r[c];
                    hold[c] = int'($urandom_range(1, 2 * DEB + 2));
                end
                hold[c]--;
            end
            s_raw = r[0]; x_raw = r[1]; sat_s_raw = r[2]; sat_x_raw = r[3];
            reset = ($urandom_range(0, 299) == 0);
            tick();
            vectors++;
            if (s_level !== m_level[0] || s_pulse !== m_pulse[0] || s_glitches !== GW'(m_glitch[0])) begin
                miscompares++;
                $display("FAIL random_s cycle %0d: got %b/%b/%0d expected %b/%b/%0d", n,
                         s_level, s_pulse, s_glitches, m_level[0], m_pulse[0], m_glitch[0]);
            end
            vectors++;
            if (x_level !== m_level[1] || x_pulse !== m_pulse[1] || x_glitches !== GW'(m_glitch[1])) begin
                miscompares++;
                $display("FAIL random_x cycle %0d: got %b/%b/%0d expected %b/%b/%0d", n,
                         x_level, x_pulse, x_glitches, m_level[1], m_pulse[1], m_glitch[1]);
            end
            vectors++;
            if (sat_s_level !== m_level[2] || sat_s_pulse !== m_pulse[2] ||
                sat_s_glitches !== GW_SAT'(m_glitch[2]) || sat_x_level !== m_level[3] ||
                sat_x_pulse !== m_pulse[3] || sat_x_glitches !== GW_SAT'(m_glitch[3])) begin
                miscompares++;
                $display("FAIL random_sat cycle %0d: got s=%b/%b/%0d x=%b/%b/%0d expected s=%b/%b/%0d x=%b/%b/%0d",
                         n, sat_s_level, sat_s_pulse, sat_s_glitches,
                         sat_x_level, sat_x_pulse, sat_x_glitches,
                         m_level[2], m_pulse[2], m_glitch[2], m_level[3], m_pulse[3], m_glitch[3]);
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_x_rise_fall();
        test_s_glitch();
        test_bounce();
        test_saturate();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that cleans the raw start (S) and count (X) inputs before they reach the counting controller. Each input passes through a two-flop synchronizer and a debounce state machine. The block then drives a clean level and a one-cycle rising-edge pulse per channel. It also keeps a saturating count of rejected glitches per channel for bring-up diagnostics.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive synchronized samples required to accept a transition; legal range 2..255.
- GLITCH_W, default 8: width of each glitch counter.
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- s_raw  input  1  asynchronous raw start input.
- x_raw  input  1  asynchronous raw count input.
- s_level  output  1  debounced S level.
- s_pulse  output  1  one-cycle pulse on each accepted S rise.
- x_level  output  1  debounced X level.
- x_pulse  output  1  one-cycle pulse on each accepted X rise.
- s_glitches  output  GLITCH_W  rejected S transitions, saturating.
- x_glitches  output  GLITCH_W  rejected X transitions, saturating.

## Operation
- The two channels are identical and independent; each has a 2-flop synchronizer (sync1 to sync2) feeding a 4-state FSM.
- States: LOW, RISE_CHK, HIGH, FALL_CHK. The debounce counter cnt is 8 bits wide.
- LOW:
  - sync2=1: go to RISE_CHK, cnt<=1.
  - Otherwise stay in LOW.
- RISE_CHK:
  - sync2=0: go to LOW, glitches+1.
  - sync2=1 and cnt==DEBOUNCE_CYCLES-1: go to HIGH, level<=1, pulse<=1.
  - sync2=1 otherwise: cnt+1.
- HIGH:
  - sync2=0: go to FALL_CHK, cnt<=1.
  - Otherwise stay in HIGH.
- FALL_CHK:
  - sync2=1: go to HIGH, glitches+1.
  - sync2=0 and cnt==DEBOUNCE_CYCLES-1: go to LOW, level<=0.
  - sync2=0 otherwise: cnt+1.
- pulse is high for exactly the one cycle after the RISE_CHK-to-HIGH edge, and low in every other cycle.
- No pulse is generated on a fall.
- level changes only on an accepted transition. It holds its value through RISE_CHK and FALL_CHK.
- Glitch counters saturate at 2^GLITCH_W-1 and never wrap. They clear only on reset.
- All outputs are registered. There is no combinational path from the raw inputs to any output.

## Timing
- Reset values: sync flops 0, state LOW, cnt 0, every level/pulse output 0, every glitch counter 0.
- Rise latency, with raw going high before edge E0 and staying stable:
  - E0 sync1=1, E1 sync2=1, E2 RISE_CHK.
  - level and pulse go high after edge E0+DEBOUNCE_CYCLES+1.
  - For the default DEBOUNCE_CYCLES=4 that is edge E5.
- Fall latency is identical: level goes low after E0+DEBOUNCE_CYCLES+1.
- Minimum accepted pulse width: DEBOUNCE_CYCLES consecutive sync2 samples. A shorter high (or low) run counts as one glitch.
- Reset mid-operation: all state returns to the reset values on the reset edge. If raw is still high, the channel re-qualifies and emits a fresh pulse DEBOUNCE_CYCLES+2 edges after reset deasserts.
- Simultaneous events on S and X are processed independently in the same cycle. There is no arbitration.
- Maximum pulse rate per channel: one pulse per 2*DEBOUNCE_CYCLES cycles.

## Structure
- Shared package cond_pkg holds:
  - the state encoding (LOW=2'd0, RISE_CHK=2'd1, HIGH=2'd2, FALL_CHK=2'd3);
  - the DEBOUNCE_CYCLES legal-range constants.
- Sub-module debounce_channel contains the synchronizer, the FSM, cnt and the glitch counter for one channel.
- input_conditioner instantiates debounce_channel twice, once for S and once for X.
- An elaboration-time check rejects DEBOUNCE_CYCLES outside 2..255.

## Test plan
- Reset, then s_raw=x_raw=0 for 20 cycles -> all outputs stay 0 and both glitch counters stay 0.
- x_raw held high from edge 0, DEBOUNCE_CYCLES=4 -> x_level rises after edge 5 and stays high; x_pulse is high for exactly one cycle; x_glitches=0.
- s_raw high for 2 cycles then low -> s_level and s_pulse never assert; s_glitches=1.
- 20 bounces (1 cycle high, 1 cycle low) followed by a stable high -> x_glitches=20 and exactly one x_pulse.
- With GLITCH_W=2, 5 glitches -> counter reads 3 and holds at 3.
- s_raw high with s_level=1, reset asserted for 1 cycle -> s_level=0 after the reset edge; s_level and s_pulse reassert 6 edges after reset deasserts.
- Both raw inputs rise on the same edge -> s_pulse and x_pulse assert in the same cycle.
